ram_1w_1rs_scheduler: RTL and testbench
=======================================

Name: ram_1w_1rs_scheduler

Overview:
Controller in front of a single-write-port, single-read-port synchronous RAM with a byte-masked write and a registered read.
- Shares the one RAM write port between two write requesters (A, B) using round-robin arbitration.
- Sequences the read port with a valid/ready command channel and a backpressured response channel.
- Blocks same-cycle read/write address collisions, because the RAM's read-under-write result is undefined.
- Optionally zero-fills the whole RAM after reset.

Parameters:
- addressWidth, 8, RAM address width; depth = 2**addressWidth.
- dataWidth, 32, RAM word width.
- maskWidth, 4, number of write-mask symbols; dataWidth must be a multiple of maskWidth.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wa_valid / wa_ready  in / out  1 / 1  write requester A handshake.
- wa_addr / wa_data / wa_mask  in  addressWidth / dataWidth / maskWidth  requester A payload.
- wb_valid / wb_ready  in / out  1 / 1  write requester B handshake.
- wb_addr / wb_data / wb_mask  in  addressWidth / dataWidth / maskWidth  requester B payload.
- rc_valid / rc_ready  in / out  1 / 1  read command handshake.
- rc_addr  in  addressWidth  read address.
- rr_valid / rr_ready  out / in  1 / 1  read response handshake.
- rr_data  out  dataWidth  read response data.
- busy  out  1  high while the init sweep runs.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_mask  out  maskWidth  RAM write mask.
- ram_wr_addr  out  addressWidth  RAM write address.
- ram_wr_data  out  dataWidth  RAM write data.
- ram_rd_en  out  1  RAM read enable.
- ram_rd_addr  out  addressWidth  RAM read address.
- ram_rd_data  in  dataWidth  RAM registered read data.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - rr_valid=0, busy=1 if init is compiled in, else 0.
  - Round-robin pointer set to "B granted last", so A wins the first tie.
  - Init counter = 0; state INIT if compiled in, else RUN.
- States: INIT -> RUN after the last address is written. RUN persists until reset.
- Reset asserted in any state, including mid-sweep, restarts from the reset values.
- INIT state:
  - Each cycle: ram_wr_en=1, ram_wr_mask all ones, ram_wr_data=0, ram_wr_addr=counter; counter increments.
  - On counter == 2**addressWidth-1, the final write is issued and the state moves to RUN; busy=0 from the next cycle.
  - wa_ready=wb_ready=rc_ready=0 throughout.
- Write arbitration (RUN state):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester not granted last.
  - The pointer updates only on a grant.
  - Exactly one of wa_ready/wb_ready is high, and only for the granted requester. The ready is combinational from valid; no ready is given without a valid.
  - The granted payload drives the ram_wr_* outputs combinationally; ram_wr_en = grant.
  - When no write is granted, ram_wr_en=0 and ram_wr_mask=0.
- Read path (RAM read latency 1):
  - rc_ready = RUN && (!rr_valid || rr_ready) && !collision.
  - collision = write granted this cycle && ram_wr_addr == rc_addr.
  - On a collision the write proceeds and the read stalls. The next cycle reads the new data.
  - ram_rd_en = rc_valid && rc_ready; ram_rd_addr = rc_addr.
  - rr_valid is set the cycle after a command fire. It clears after rr_valid && rr_ready when no new fire occurs.
  - A simultaneous response pop and new fire keep rr_valid=1, with the new data on the next cycle.
  - rr_data = ram_rd_data directly. It stays stable while rr_valid && !rr_ready, because ram_rd_en is held low during that time.
- Throughput: one write and one read can be accepted every cycle; a full-rate read stream requires rr_ready held high.
- Writes to different addresses in back-to-back cycles need no stall. Only the same-cycle address collision is blocked.

Optional Feature:
- Macro RAM_SCHED_INIT_EN.
  - Defined: INIT zero-fill sweep as above; 2**addressWidth cycles after reset before any request is accepted.
  - Undefined: no INIT state and no counter; busy is tied to 0, and the block is in RUN from the first cycle after reset.

Test Plan:
- Init: reset then release with the macro on and addressWidth=4 -> 16 consecutive writes to addresses 0..15 (data 0, mask 0xF), busy falls at cycle 16, then reading address 7 returns 0.
- Round-robin: wa_valid and wb_valid held high for 4 cycles at addresses 1 and 2 -> grants A,B,A,B; then B alone for 2 cycles -> B,B; next tie -> A.
- Masked write: write 0x11223344 mask 0xF to address 3, then 0xAABBCCDD mask 0x5 -> reading address 3 returns 0x11BB33DD.
- Collision: a write to address 5 and a read of address 5 in the same cycle -> rc_ready=0 that cycle, the read fires next cycle, rr_data = new value.
- Backpressure: 3 reads with rr_ready=0 -> first response held stable, rc_ready=0. Raise rr_ready -> responses arrive in order, one per cycle, with no loss.
- Reset mid-sweep: assert reset at init counter 9 -> the next sweep restarts at address 0, and no requests are accepted before the sweep completes.

Source files
------------

// File: rtl/ram_1w_1rs_scheduler.sv
// Write-port arbiter (round-robin A/B) and read sequencer for a 1W/1R synchronous RAM.
// Define RAM_SCHED_INIT_EN to zero-fill the whole RAM after reset before accepting requests.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_INIT | zero-fill sweep, one word per cycle, all requesters held off
// ST_RUN  | normal operation: arbitrated writes, handshaked reads
module ram_1w_1rs_scheduler #(
    parameter int addressWidth = 8,
    parameter int dataWidth    = 32,
    parameter int maskWidth    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wa_valid,
    output logic                    wa_ready,
    input  logic [addressWidth-1:0] wa_addr,
    input  logic [dataWidth-1:0]    wa_data,
    input  logic [maskWidth-1:0]    wa_mask,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [addressWidth-1:0] wb_addr,
    input  logic [dataWidth-1:0]    wb_data,
    input  logic [maskWidth-1:0]    wb_mask,
    input  logic                    rc_valid,
    output logic                    rc_ready,
    input  logic [addressWidth-1:0] rc_addr,
    output logic                    rr_valid,
    input  logic                    rr_ready,
    output logic [dataWidth-1:0]    rr_data,
    output logic                    busy,
    output logic                    ram_wr_en,
    output logic [maskWidth-1:0]    ram_wr_mask,
    output logic [addressWidth-1:0] ram_wr_addr,
    output logic [dataWidth-1:0]    ram_wr_data,
    output logic                    ram_rd_en,
    output logic [addressWidth-1:0] ram_rd_addr,
    input  logic [dataWidth-1:0]    ram_rd_data
);

    logic run;
    logic last_b;
    logic grant_a;
    logic grant_b;
    logic collision;
    logic rd_fire;

`ifdef RAM_SCHED_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state;
    logic [addressWidth-1:0] init_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            busy     <= 1'b1;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == '1) begin
                state <= ST_RUN;
                busy  <= 1'b0;
            end
        end
    end

    assign run = (state == ST_RUN);
`else
    assign run  = 1'b1;
    assign busy = 1'b0;
`endif

    // last_b=1 means B won the previous grant, so A takes the next tie.
    assign grant_a  = run && wa_valid && (!wb_valid || last_b);
    assign grant_b  = run && wb_valid && (!wa_valid || !last_b);
    assign wa_ready = grant_a;
    assign wb_ready = grant_b;

    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_mask = '0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
`ifdef RAM_SCHED_INIT_EN
        if (state == ST_INIT) begin
            ram_wr_en   = 1'b1;
            ram_wr_mask = '1;
            ram_wr_addr = init_cnt;
        end
`endif
        if (grant_a) begin
            ram_wr_en   = 1'b1;
            ram_wr_mask = wa_mask;
            ram_wr_addr = wa_addr;
            ram_wr_data = wa_data;
        end else if (grant_b) begin
            ram_wr_en   = 1'b1;
            ram_wr_mask = wb_mask;
            ram_wr_addr = wb_addr;
            ram_wr_data = wb_data;
        end
    end

    // Read-under-write is undefined in the RAM, so a same-address read waits one cycle.
    assign collision   = (grant_a || grant_b) && (ram_wr_addr == rc_addr);
    assign rc_ready    = run && (!rr_valid || rr_ready) && !collision;
    assign rd_fire     = rc_valid && rc_ready;
    assign ram_rd_en   = rd_fire;
    assign ram_rd_addr = rc_addr;
    assign rr_data     = ram_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_valid <= 1'b0;
            last_b   <= 1'b1;
        end else begin
            if (rd_fire) begin
                rr_valid <= 1'b1;
            end else if (rr_ready) begin
                rr_valid <= 1'b0;
            end
            if (grant_a) begin
                last_b <= 1'b0;
            end else if (grant_b) begin
                last_b <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_1w_1rs_scheduler.sv
// Bench for ram_1w_1rs_scheduler: behavioural RAM, directed scenarios, then random traffic
// checked against a queue-based reference model.
module tb_ram_1w_1rs_scheduler;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int DEPTH = 16;
    localparam int SW    = DW / MW;
    localparam logic [DW-1:0] INIT_PAT = 32'hA5C30000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wa_valid = 1'b0, wb_valid = 1'b0, rc_valid = 1'b0, rr_ready = 1'b1;
    logic          wa_ready, wb_ready, rc_ready, rr_valid, busy;
    logic [AW-1:0] wa_addr = '0, wb_addr = '0, rc_addr = '0;
    logic [DW-1:0] wa_data = '0, wb_data = '0;
    logic [MW-1:0] wa_mask = '0, wb_mask = '0;
    logic [DW-1:0] rr_data;
    logic          ram_wr_en, ram_rd_en;
    logic [MW-1:0] ram_wr_mask;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data;
    logic [DW-1:0] ram_rd_data;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] rsp_q   [$];
    bit            prefer_a;
    logic          obs_wa, obs_wb, obs_rcr;

    always #5 clk = ~clk;

    ram_1w_1rs_scheduler #(.addressWidth(AW), .dataWidth(DW), .maskWidth(MW)) dut (
        .clk(clk), .reset(reset),
        .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data), .wa_mask(wa_mask),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data), .wb_mask(wb_mask),
        .rc_valid(rc_valid), .rc_ready(rc_ready), .rc_addr(rc_addr),
        .rr_valid(rr_valid), .rr_ready(rr_ready), .rr_data(rr_data),
        .busy(busy),
        .ram_wr_en(ram_wr_en), .ram_wr_mask(ram_wr_mask), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [MW-1:0] mask);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < MW; i++)
            if (mask[i]) r[i*SW +: SW] = new_w[i*SW +: SW];
        return r;
    endfunction

    // Behavioural RAM with registered read.
    always @(posedge clk) begin
        if (ram_wr_en) ram[ram_wr_addr] <= merge(ram[ram_wr_addr], ram_wr_data, ram_wr_mask);
        if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One RUN-state cycle: inputs already driven just after negedge; compare against the model.
    task automatic cycle();
        bit            ga, gb, exp_rrv, exp_rcr;
        logic [AW-1:0] wad;
        logic [DW-1:0] wdat;
        logic [MW-1:0] wmk;
        #1;
        ga   = wa_valid && (!wb_valid || prefer_a);
        gb   = wb_valid && (!wa_valid || !prefer_a);
        wad  = ga ? wa_addr : wb_addr;
        wdat = ga ? wa_data : wb_data;
        wmk  = ga ? wa_mask : wb_mask;
        obs_wa  = wa_ready;
        obs_wb  = wb_ready;
        obs_rcr = rc_ready;
        check("wa_ready", wa_ready, ga);
        check("wb_ready", wb_ready, gb);
        check("wr_en", ram_wr_en, ga || gb);
        if (ga || gb) begin
            check("wr_addr", ram_wr_addr, wad);
            check("wr_data", ram_wr_data, wdat);
            check("wr_mask", ram_wr_mask, wmk);
        end else begin
            check("wr_mask_idle", ram_wr_mask, '0);
        end
        exp_rrv = (rsp_q.size() != 0);
        check("rr_valid", rr_valid, exp_rrv);
        if (exp_rrv) check("rr_data", rr_data, rsp_q[0]);
        exp_rcr = (!exp_rrv || rr_ready) && !((ga || gb) && wad == rc_addr);
        check("rc_ready", rc_ready, exp_rcr);
        if (exp_rrv && rr_ready) void'(rsp_q.pop_front());
        if (rc_valid && exp_rcr) rsp_q.push_back(ref_mem[rc_addr]);
        if (ga || gb) ref_mem[wad] = merge(ref_mem[wad], wdat, wmk);
        if (ga) prefer_a = 1'b0;
        else if (gb) prefer_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wa_valid = 1'b0;
        wb_valid = 1'b0;
        rc_valid = 1'b0;
        rr_ready = 1'b1;
    endtask

    task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        wa_valid = 1'b1; wa_addr = a; wa_data = d; wa_mask = m;
    endtask

    initial begin
        bit       exp_a [7];
        bit       exp_b [7];
        logic [DW-1:0] v8, v9, v10;

        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = INIT_PAT | DW'(i);
            ref_mem[i] = INIT_PAT | DW'(i);
        end
        prefer_a = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

`ifdef RAM_SCHED_INIT_EN
        // Requests held high throughout the sweep must never be accepted.
        wa_valid = 1'b1; wb_valid = 1'b1; rc_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("sweep1_addr", ram_wr_addr, k);
            check("sweep1_busy", busy, 1);
            if (k == 9) reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            check("sweep_busy", busy, 1);
            check("sweep_en", ram_wr_en, 1);
            check("sweep_addr", ram_wr_addr, k);
            check("sweep_mask", ram_wr_mask, 4'hF);
            check("sweep_data", ram_wr_data, 0);
            check("sweep_rdy", {wa_ready, wb_ready, rc_ready}, 0);
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        idle();
        check("busy_after_sweep", busy, 0);
`else
        idle();
        check("busy_off", busy, 0);
`endif
        check("reset_rr_valid", rr_valid, 0);

        // Read address 7 straight after init.
        rc_valid = 1'b1; rc_addr = 4'd7;
        cycle();
        rc_valid = 1'b0;
`ifdef RAM_SCHED_INIT_EN
        check("init_read7", rr_data, 0);
`else
        check("init_read7", rr_data, INIT_PAT | 32'd7);
`endif
        cycle();

        // Round-robin: 4 ties, 2 B-only, 1 tie.
        exp_a = '{1, 0, 1, 0, 0, 0, 1};
        exp_b = '{0, 1, 0, 1, 1, 1, 0};
        wa_addr = 4'd1; wb_addr = 4'd2; wa_mask = 4'hF; wb_mask = 4'hF;
        for (int k = 0; k < 7; k++) begin
            wa_valid = !(k == 4 || k == 5);
            wb_valid = 1'b1;
            wa_data  = $urandom;
            wb_data  = $urandom;
            cycle();
            check("rr_seq_a", obs_wa, exp_a[k]);
            check("rr_seq_b", obs_wb, exp_b[k]);
        end
        idle();

        // Masked write.
        write_a(4'd3, 32'h11223344, 4'hF);
        cycle();
        write_a(4'd3, 32'hAABBCCDD, 4'h5);
        cycle();
        idle();
        rc_valid = 1'b1; rc_addr = 4'd3;
        cycle();
        rc_valid = 1'b0;
        check("masked_read", rr_data, 32'h11BB33DD);
        cycle();

        // Collision: same-cycle write/read of address 5.
        write_a(4'd5, 32'h55AA55AA, 4'hF);
        rc_valid = 1'b1; rc_addr = 4'd5;
        cycle();
        check("collision_stall", obs_rcr, 0);
        wa_valid = 1'b0;
        cycle();
        check("collision_fire", obs_rcr, 1);
        rc_valid = 1'b0;
        check("collision_data", rr_data, 32'h55AA55AA);
        cycle();

        // Backpressure.
        v8 = $urandom; v9 = $urandom; v10 = $urandom;
        write_a(4'd8, v8, 4'hF);  cycle();
        write_a(4'd9, v9, 4'hF);  cycle();
        write_a(4'd10, v10, 4'hF); cycle();
        idle();
        rr_ready = 1'b0;
        rc_valid = 1'b1; rc_addr = 4'd8;
        cycle();
        rc_addr = 4'd9;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_stall", obs_rcr, 0);
            check("bp_hold", rr_data, v8);
        end
        rr_ready = 1'b1;
        cycle();
        rc_addr = 4'd10;
        check("bp_resp2", rr_data, v9);
        cycle();
        rc_valid = 1'b0;
        check("bp_resp3", rr_data, v10);
        cycle();
        cycle();

        // Random traffic on a narrow address window to provoke collisions and ties.
        for (int k = 0; k < 400; k++) begin
            wa_valid = ($urandom_range(0, 1) == 1);
            wb_valid = ($urandom_range(0, 1) == 1);
            rc_valid = ($urandom_range(0, 2) != 0);
            rr_ready = ($urandom_range(0, 3) != 0);
            wa_addr  = AW'($urandom_range(0, 3));
            wb_addr  = AW'($urandom_range(0, 3));
            rc_addr  = AW'($urandom_range(0, 3));
            wa_data  = $urandom;
            wb_data  = $urandom;
            wa_mask  = MW'($urandom);
            wb_mask  = MW'($urandom);
            cycle();
        end
        idle();
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
